imem_loader: RTL and testbench

- Writer side of the instruction memory: receives the program as a byte stream over a valid/ready handshake.
- Assembles big-endian 32-bit words and writes them sequentially into instruction memory, starting at byte address 0.
- Holds the CPU in reset until the end-of-program sentinel word has been written.
- Sits between the board/host byte link and the instruction memory write port; the fetch path keeps reading with word index = byte address / 4.

---
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Collects a byte stream over a valid/ready handshake and packs it into
// big-endian 32-bit words. Each word is written to consecutive word-aligned
// addresses starting at byte address 0. The CPU is held in reset until the
// end-of-program sentinel word has been written. Every output is registered.
module imem_loader #(
    parameter int          ADDR_W   = 13,
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [31:0]       mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam int                PAD_W    = 30 - ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       shift_q;
    logic              byte_accept;

    // A byte moves only when both sides agree in the same cycle.
    assign byte_accept = byte_valid & byte_ready;

    // Load sequencer: byte assembly, write strobe generation and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            word_idx     <= '0;
            byte_idx     <= '0;
            shift_q      <= '0;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            word_count   <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LOAD;
                        byte_ready   <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        overflow_err <= 1'b0;
                        word_idx     <= '0;
                        byte_idx     <= '0;
                        word_count   <= '0;
                    end
                end
                S_LOAD: begin
                    if (byte_accept) begin
                        shift_q  <= {shift_q[15:0], byte_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_waddr  <= {{PAD_W{1'b0}}, word_idx, 2'b00};
                            mem_wdata  <= {shift_q, byte_data};
                            word_count <= word_count + CNT_ONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_wdata == END_WORD) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (word_idx == LAST_IDX) begin
                        state        <= S_ERR;
                        overflow_err <= 1'b1;
                    end else begin
                        state      <= S_LOAD;
                        word_idx   <= word_idx + IDX_ONE;
                        byte_idx   <= '0;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader.
// Two instances share one stimulus stream. The first uses the full 8192-word
// depth and the second uses an 8-word depth, so overflow can be reached quickly.
// A cycle-accurate vector table covers the basic handshake timing.
// Randomized programs are checked against a word-level reference model.
module tb_imem_loader;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        exp_ready;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_done;
        logic        exp_hold;
        int          exp_wc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    localparam int ST_LOADING = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int NVEC       = 24;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        byte_ready_s [2];
    logic        mem_we_s     [2];
    logic [31:0] mem_waddr_s  [2];
    logic [31:0] mem_wdata_s  [2];
    logic        cpu_hold_s   [2];
    logic        done_s       [2];
    logic        ovf_s        [2];
    logic [31:0] wc_s         [2];
    logic [13:0] wc_big;
    logic [3:0]  wc_small;

    assign wc_s[0] = {18'b0, wc_big};
    assign wc_s[1] = {28'b0, wc_small};

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_we [2];

    logic [7:0] tx_q [$];
    wr_t        obs0 [$];
    wr_t        obs1 [$];
    wr_t        exp_q [$];
    int         exp_status;
    vec_t       vecs [NVEC];

    imem_loader dut_big (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready_s[0]), .mem_we(mem_we_s[0]),
        .mem_waddr(mem_waddr_s[0]), .mem_wdata(mem_wdata_s[0]),
        .cpu_hold(cpu_hold_s[0]), .done(done_s[0]),
        .overflow_err(ovf_s[0]), .word_count(wc_big)
    );

    imem_loader #(.ADDR_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready_s[1]), .mem_we(mem_we_s[1]),
        .mem_waddr(mem_waddr_s[1]), .mem_wdata(mem_wdata_s[1]),
        .cpu_hold(cpu_hold_s[1]), .done(done_s[1]),
        .overflow_err(ovf_s[1]), .word_count(wc_small)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: records every write and checks the strobe rules.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_we_s[k] === 1'b1) begin
                wr_t w;
                checkOutput($sformatf("dut%0d ready_low_in_write", k), {31'b0, byte_ready_s[k]}, 32'd0);
                checkOutput($sformatf("dut%0d we_back_to_back", k), {31'b0, prev_we[k]}, 32'd0);
                w.addr = mem_waddr_s[k];
                w.data = mem_wdata_s[k];
                if (k == 0) obs0.push_back(w);
                else        obs1.push_back(w);
            end
            prev_we[k] = (mem_we_s[k] === 1'b1);
        end
    end

    function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic r, logic we,
                                logic [31:0] a, logic [31:0] dat, logic dn, logic h, int wc);
        vec_t x;
        x.start = s; x.valid = v; x.data = d;
        x.exp_ready = r; x.exp_we = we; x.exp_addr = a; x.exp_data = dat;
        x.exp_done = dn; x.exp_hold = h; x.exp_wc = wc;
        return x;
    endfunction

    task automatic applyStimulus(input vec_t v);
        start      = v.start;
        byte_valid = v.valid;
        byte_data  = v.data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        checkOutput($sformatf("%s dut%0d byte_ready", tag, k), {31'b0, byte_ready_s[k]}, 32'd0);
        checkOutput($sformatf("%s dut%0d mem_we", tag, k), {31'b0, mem_we_s[k]}, 32'd0);
        checkOutput($sformatf("%s dut%0d mem_waddr", tag, k), mem_waddr_s[k], 32'd0);
        checkOutput($sformatf("%s dut%0d mem_wdata", tag, k), mem_wdata_s[k], 32'd0);
        checkOutput($sformatf("%s dut%0d cpu_hold", tag, k), {31'b0, cpu_hold_s[k]}, 32'd1);
        checkOutput($sformatf("%s dut%0d done", tag, k), {31'b0, done_s[k]}, 32'd0);
        checkOutput($sformatf("%s dut%0d overflow_err", tag, k), {31'b0, ovf_s[k]}, 32'd0);
        checkOutput($sformatf("%s dut%0d word_count", tag, k), wc_s[k], 32'd0);
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[31:8] = 24'hFF_FFFF;
        if (w == 32'hFFFF_FFFF) w = 32'hFFFF_FFFE;
        return w;
    endfunction

    // Offers tx_q bytes with random gaps; a byte advances only on a handshake.
    task automatic send_bytes(input int pct);
        int idx = 0;
        int cycles = 0;
        while (idx < tx_q.size() && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            byte_valid = ($urandom_range(0, 99) < pct);
            byte_data  = byte_valid ? tx_q[idx] : 8'($urandom);
            if (byte_valid && byte_ready_s[0]) idx++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        checkOutput("bytes_delivered_in_time", idx, tx_q.size());
    endtask

    // Reference model: cut the stream into words, write them in order, and stop at
    // the sentinel (done) or when the memory is full (error).
    task automatic run_model(input int depth);
        wr_t e;
        exp_q.delete();
        exp_status = ST_LOADING;
        for (int w = 0; (w + 1) * 4 <= tx_q.size(); w++) begin
            e.addr = 32'(w * 4);
            e.data = {tx_q[4*w], tx_q[4*w+1], tx_q[4*w+2], tx_q[4*w+3]};
            exp_q.push_back(e);
            if (e.data == 32'hFFFF_FFFF) begin
                exp_status = ST_DONE;
                break;
            end
            if (w + 1 == depth) begin
                exp_status = ST_ERR;
                break;
            end
        end
    endtask

    task automatic check_load(input int k, input string tag);
        wr_t cur [$];
        run_model((k == 0) ? 8192 : 8);
        if (k == 0) cur = obs0;
        else        cur = obs1;
        checkOutput($sformatf("%s dut%0d write_count", tag, k), cur.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cur.size(); i++) begin
            checkOutput($sformatf("%s dut%0d waddr[%0d]", tag, k, i), cur[i].addr, exp_q[i].addr);
            checkOutput($sformatf("%s dut%0d wdata[%0d]", tag, k, i), cur[i].data, exp_q[i].data);
        end
        checkOutput($sformatf("%s dut%0d word_count", tag, k), wc_s[k], exp_q.size());
        checkOutput($sformatf("%s dut%0d done", tag, k), {31'b0, done_s[k]}, {31'b0, exp_status == ST_DONE});
        checkOutput($sformatf("%s dut%0d overflow_err", tag, k), {31'b0, ovf_s[k]}, {31'b0, exp_status == ST_ERR});
        checkOutput($sformatf("%s dut%0d cpu_hold", tag, k), {31'b0, cpu_hold_s[k]}, {31'b0, exp_status != ST_DONE});
        checkOutput($sformatf("%s dut%0d byte_ready", tag, k), {31'b0, byte_ready_s[k]}, {31'b0, exp_status == ST_LOADING});
    endtask

    initial begin
        prev_we[0] = 1'b0; prev_we[1] = 1'b0;
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

        //            start valid data   ready we addr  data          done hold wc
        vecs[0]  = mk(1, 0, 8'h00, 1, 0, 32'h0, 32'h0,         0, 1, 0);
        vecs[1]  = mk(0, 1, 8'h20, 1, 0, 32'h0, 32'h0,         0, 1, 0);
        vecs[2]  = mk(0, 1, 8'h08, 1, 0, 32'h0, 32'h0,         0, 1, 0);
        vecs[3]  = mk(0, 1, 8'h00, 1, 0, 32'h0, 32'h0,         0, 1, 0);
        vecs[4]  = mk(0, 1, 8'h05, 0, 1, 32'h0, 32'h2008_0005, 0, 1, 1);
        vecs[5]  = mk(0, 1, 8'hFF, 1, 0, 32'h0, 32'h2008_0005, 0, 1, 1);
        vecs[6]  = mk(0, 1, 8'hFF, 1, 0, 32'h0, 32'h2008_0005, 0, 1, 1);
        vecs[7]  = mk(0, 1, 8'hFF, 1, 0, 32'h0, 32'h2008_0005, 0, 1, 1);
        vecs[8]  = mk(0, 1, 8'hFF, 1, 0, 32'h0, 32'h2008_0005, 0, 1, 1);
        vecs[9]  = mk(0, 1, 8'hFF, 0, 1, 32'h4, 32'hFFFF_FFFF, 0, 1, 2);
        vecs[10] = mk(0, 0, 8'h00, 0, 0, 32'h4, 32'hFFFF_FFFF, 1, 0, 2);
        vecs[11] = mk(0, 1, 8'hAB, 0, 0, 32'h4, 32'hFFFF_FFFF, 1, 0, 2);
        vecs[12] = mk(0, 1, 8'hCD, 0, 0, 32'h4, 32'hFFFF_FFFF, 1, 0, 2);
        vecs[13] = mk(1, 0, 8'h00, 1, 0, 32'h4, 32'hFFFF_FFFF, 0, 1, 0);
        vecs[14] = mk(0, 1, 8'h12, 1, 0, 32'h4, 32'hFFFF_FFFF, 0, 1, 0);
        vecs[15] = mk(1, 1, 8'h34, 1, 0, 32'h4, 32'hFFFF_FFFF, 0, 1, 0);
        vecs[16] = mk(0, 1, 8'h56, 1, 0, 32'h4, 32'hFFFF_FFFF, 0, 1, 0);
        vecs[17] = mk(0, 1, 8'h78, 0, 1, 32'h0, 32'h1234_5678, 0, 1, 1);
        vecs[18] = mk(1, 0, 8'h00, 1, 0, 32'h0, 32'h1234_5678, 0, 1, 1);
        vecs[19] = mk(0, 1, 8'hFF, 1, 0, 32'h0, 32'h1234_5678, 0, 1, 1);
        vecs[20] = mk(0, 1, 8'hFF, 1, 0, 32'h0, 32'h1234_5678, 0, 1, 1);
        vecs[21] = mk(0, 1, 8'hFF, 1, 0, 32'h0, 32'h1234_5678, 0, 1, 1);
        vecs[22] = mk(0, 1, 8'hFF, 0, 1, 32'h4, 32'hFFFF_FFFF, 0, 1, 2);
        vecs[23] = mk(0, 0, 8'h00, 0, 0, 32'h4, 32'hFFFF_FFFF, 1, 0, 2);

        $display("[TB] reset and vector table");
        do_reset();
        for (int k = 0; k < 2; k++) check_reset_vals(k, "after_reset");

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("vec%0d dut%0d byte_ready", i, k), {31'b0, byte_ready_s[k]}, {31'b0, vecs[i].exp_ready});
                checkOutput($sformatf("vec%0d dut%0d mem_we", i, k), {31'b0, mem_we_s[k]}, {31'b0, vecs[i].exp_we});
                checkOutput($sformatf("vec%0d dut%0d mem_waddr", i, k), mem_waddr_s[k], vecs[i].exp_addr);
                checkOutput($sformatf("vec%0d dut%0d mem_wdata", i, k), mem_wdata_s[k], vecs[i].exp_data);
                checkOutput($sformatf("vec%0d dut%0d done", i, k), {31'b0, done_s[k]}, {31'b0, vecs[i].exp_done});
                checkOutput($sformatf("vec%0d dut%0d cpu_hold", i, k), {31'b0, cpu_hold_s[k]}, {31'b0, vecs[i].exp_hold});
                checkOutput($sformatf("vec%0d dut%0d overflow_err", i, k), {31'b0, ovf_s[k]}, 32'd0);
                checkOutput($sformatf("vec%0d dut%0d word_count", i, k), wc_s[k], vecs[i].exp_wc);
            end
        end
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b0;

        $display("[TB] reset in the middle of word 3");
        do_reset();
        obs0.delete(); obs1.delete();
        do_start();
        tx_q.delete();
        push_word(32'hA1B2_C3D4);
        push_word(32'h0102_0304);
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h66);
        send_bytes(100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_reset_vals(k, "midload_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midload dut0 writes_before_reset", obs0.size(), 32'd2);
        checkOutput("midload dut1 writes_before_reset", obs1.size(), 32'd2);
        obs0.delete(); obs1.delete();
        do_start();
        tx_q.delete();
        push_word(32'h1234_5678);
        push_word(32'hFFFF_FFFF);
        send_bytes(50);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) check_load(k, "after_midload");

        $display("[TB] overflow of the 8-word instance");
        do_reset();
        obs0.delete(); obs1.delete();
        do_start();
        tx_q.delete();
        for (int i = 0; i < 9; i++) push_word(rand_word());
        send_bytes(100);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) check_load(k, "overflow");
        do_start();
        checkOutput("restart_from_err dut1 overflow_err", {31'b0, ovf_s[1]}, 32'd0);
        checkOutput("restart_from_err dut1 byte_ready", {31'b0, byte_ready_s[1]}, 32'd1);
        checkOutput("restart_from_err dut1 cpu_hold", {31'b0, cpu_hold_s[1]}, 32'd1);
        checkOutput("restart_from_err dut1 word_count", wc_s[1], 32'd0);
        checkOutput("start_in_load dut0 word_count", wc_s[0], 32'd9);

        $display("[TB] randomized programs");
        do_reset();
        for (int it = 0; it < 8; it++) begin
            int len;
            obs0.delete(); obs1.delete();
            do_start();
            tx_q.delete();
            len = $urandom_range(1, 10);
            for (int i = 0; i < len - 1; i++) push_word(rand_word());
            push_word(32'hFFFF_FFFF);
            send_bytes($urandom_range(25, 100));
            repeat (3) @(negedge clk);
            for (int k = 0; k < 2; k++) check_load(k, $sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
